spi_frame_engine: RTL

Fabric-clocked SPI master that sits between the JTAG-side byte deserializer and the configuration SPI flash pins, replacing the raw DRCK-as-SCK passthrough. It accepts framed byte streams (header plus payload), drives the flash in SPI mode 0 at a programmable divided rate, and returns captured read bytes upstream. Frame-controlled chip-select allows multi-frame flash transactions such as a command frame followed by a read frame.

---
 rtl/spi_frame_pkg.sv | 21 ++
 rtl/spi_frame_if.sv | 17 +
 rtl/spi_byte_shifter.sv | 74 +++++++
 rtl/spi_frame_engine.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame engine.
//   state_t      : frame FSM states
//   FLAG_*       : bit positions inside the header flags byte
//   HDR_BYTES    : header length in bytes (flags, len_hi, len_lo)
package spi_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LEN_H,
    ST_HDR_LEN_L,
    ST_LOAD,
    ST_SHIFT,
    ST_PUSH,
    ST_END
  } state_t;

  localparam int unsigned FLAG_KEEP_CS = 0;
  localparam int unsigned FLAG_RX_EN   = 1;
  localparam int unsigned HDR_BYTES    = 3;

endpackage

// File: rtl/spi_frame_if.sv
// Byte-stream handshake between the upstream deserializer and the engine.
//   in_data/in_valid/in_ready    : inbound header + payload bytes
//   out_data/out_valid/out_ready : bytes captured from the flash
//   master : upstream side, slave : engine side
interface spi_frame_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte transfer, MSB first, at a divided rate.
//   start   : 1-cycle pulse, loads tx_byte and begins shifting
//   tx_byte : byte to send
//   done    : 1-cycle pulse in the cycle after the 8th sck fall
//   rx_byte : byte sampled from sdo_dq1 (valid with done)
//   sck, sdi_dq0 : registered flash clock and MOSI
//   sdo_dq1 : MISO, sampled on the clk edge that raises sck
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       sdo_dq1,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       sdi_dq0
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sr;   // bits still to be presented after sdi_dq0
  logic             active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      sck     <= 1'b0;
      sdi_dq0 <= 1'b0;
      done    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_byte <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        sck     <= 1'b0;
        sdi_dq0 <= tx_byte[7];
        tx_sr   <= {tx_byte[6:0], 1'b0};
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (!sck) begin
            sck     <= 1'b1;
            rx_byte <= {rx_byte[6:0], sdo_dq1};
          end else begin
            // falling edge: next MOSI bit changes together with sck going low
            sck <= 1'b0;
            if (bit_cnt == 3'd7) begin
              active <= 1'b0;
              done   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sdi_dq0 <= tx_sr[7];
              tx_sr   <= {tx_sr[6:0], 1'b0};
            end
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_frame_engine.sv
// Framed SPI master for configuration flash access.
//   clk, rst : clock, synchronous active-high reset
//   up       : byte-stream handshake (slave side)
//   busy     : frame in progress or chip-select held low
//   csn, sck, sdi_dq0 : registered flash pins; sdo_dq1 : MISO
//   wpn_dq2, hldn_dq3 : tied high
// Frame: flags byte, 16-bit (length-1) MSB first, then the payload.
module spi_frame_engine
  import spi_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  spi_frame_if.slave  up,
  output logic        busy,
  output logic        csn,
  output logic        sck,
  output logic        sdi_dq0,
  input  logic        sdo_dq1,
  output logic        wpn_dq2,
  output logic        hldn_dq3
);

  localparam int unsigned WAIT_W = $clog2(2 * CLK_DIV + 1);

  state_t              state;
  logic                keep_cs;
  logic                rx_en;
  logic [7:0]          len_hi;
  logic [LEN_W-1:0]    len_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                start;
  logic [7:0]          tx_byte;
  logic                done;
  logic [7:0]          rx_byte;
  logic                accept;
  logic                advance;

  assign accept   = up.in_valid & up.in_ready;
  assign busy     = (state != ST_IDLE) | ~csn;
  assign wpn_dq2  = 1'b1;
  assign hldn_dq3 = 1'b1;

  // a payload byte has fully finished (shifted, and pushed when reading)
  always_comb begin
    advance = 1'b0;
    if (state == ST_SHIFT && wait_cnt == '0 && done && !rx_en) advance = 1'b1;
    if (state == ST_PUSH && up.out_ready) advance = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      up.in_ready  <= 1'b0;
      up.out_valid <= 1'b0;
      up.out_data  <= '0;
      csn          <= 1'b1;
      start        <= 1'b0;
      wait_cnt     <= '0;
      keep_cs      <= 1'b0;
      rx_en        <= 1'b0;
      len_hi       <= '0;
      len_cnt      <= '0;
      tx_byte      <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          up.in_ready <= 1'b1;
          if (accept) begin
            keep_cs <= up.in_data[FLAG_KEEP_CS];
            rx_en   <= up.in_data[FLAG_RX_EN];
            state   <= ST_HDR_LEN_H;
          end
        end
        ST_HDR_LEN_H: if (accept) begin
          len_hi <= up.in_data;
          state  <= ST_HDR_LEN_L;
        end
        ST_HDR_LEN_L: if (accept) begin
          len_cnt <= LEN_W'({len_hi, up.in_data});
          state   <= ST_LOAD;
        end
        ST_LOAD: if (accept) begin
          tx_byte     <= up.in_data;
          up.in_ready <= 1'b0;
          state       <= ST_SHIFT;
          // fresh select: hold off the shifter for the CS setup time
          if (csn) begin
            csn      <= 1'b0;
            wait_cnt <= WAIT_W'(CLK_DIV);
          end else begin
            start <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
            if (wait_cnt == WAIT_W'(1)) start <= 1'b1;
          end else if (done && rx_en) begin
            up.out_data  <= rx_byte;
            up.out_valid <= 1'b1;
            state        <= ST_PUSH;
          end
        end
        ST_PUSH: if (up.out_ready) up.out_valid <= 1'b0;
        ST_END: begin
          // csn low: hold time before release; csn high: deselect time
          if (keep_cs) begin
            state <= ST_IDLE;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (!csn) begin
            csn      <= 1'b1;
            wait_cnt <= WAIT_W'(2 * CLK_DIV - 1);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (advance) begin
        if (len_cnt == '0) begin
          state    <= ST_END;
          wait_cnt <= WAIT_W'(CLK_DIV - 1);
        end else begin
          len_cnt     <= len_cnt - 1'b1;
          state       <= ST_LOAD;
          up.in_ready <= 1'b1;
        end
      end
    end
  end

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_byte (tx_byte),
    .sdo_dq1 (sdo_dq1),
    .done    (done),
    .rx_byte (rx_byte),
    .sck     (sck),
    .sdi_dq0 (sdi_dq0)
  );

endmodule
